i2s_rx: RTL and testbench
=========================

Name: i2s_rx

Overview:
- I2S serial-to-parallel receiver: deserialises a stereo I2S stream (standard Philips format, MSB first, 1-bit delay after the LRCLK edge) into left/right parallel words.
- Sits between the external codec/ADC pins and the demodulator sample pipeline.
- It is the receive-side counterpart of the team's I2S transmitter: 32-bit slots, 24 valid MSBs, LRCLK low = left.
- Runs entirely in the sclk domain; CDC into the system clock is done downstream.

Parameters:
- DATA_RES, 24, captured bits per channel (MSB-aligned in the slot).
- SLOT_BITS, 32, nominal sclk periods per channel. Elaboration check: DATA_RES+1 <= SLOT_BITS.

Ports:
- sclk  input  1  bit clock; all logic on posedge.
- reset  input  1  synchronous, active-high.
- lrclk  input  1  word select; 0 = left, 1 = right; sampled on posedge sclk.
- i_sdin  input  1  serial data, sampled on posedge sclk.
- o_ldout  output  DATA_RES  last complete left word.
- o_rdout  output  DATA_RES  last complete right word.
- o_valid  output  1  one-sclk pulse when a new L/R pair is presented.
- o_frame_err  output  1  one-sclk pulse on slot-length error (see Optional Feature).

Behaviour:
- Reset: o_ldout=0, o_rdout=0, o_valid=0, o_frame_err=0, state=SYNC, lrclk_d=1, bit counter=0, shift regs=0.
- Edge detect: lrclk_d is lrclk registered each posedge. An edge cycle (k=0) is any posedge where lrclk != lrclk_d.
- Slot indexing: k increments each posedge after an edge and saturates at SLOT_BITS+1. It needs at least $clog2(SLOT_BITS+2) bits.
- Data capture: i_sdin at k=1..DATA_RES is shifted in MSB first. Bits at k>DATA_RES are ignored. The sdin at k=0 is the previous slot's last bit and is discarded.
- FSM states: SYNC, LEFT, RIGHT.
  - SYNC: ignore data. A falling lrclk edge goes to LEFT; a rising edge stays in SYNC, so the first delivered pair is always a complete left then right.
  - LEFT: on the cycle k=DATA_RES, latch the left shift reg into an internal hold reg, not the output. A rising edge goes to RIGHT.
  - RIGHT: on the cycle k=DATA_RES, when the left hold is valid, present both channels (see Output update).
  - RIGHT: a falling edge goes to LEFT and clears the left-hold-valid flag.
- Output update: o_ldout/o_rdout update together, in the posedge after the right LSB is sampled. o_valid=1 for exactly that one cycle. Latency from the right LSB sample edge to o_valid is 1 sclk.
- Output hold: outputs hold their value between updates; no handshake and no backpressure.
- Short slot: an edge arriving before k reaches DATA_RES drops that channel. No latch; if it was the left channel, no o_valid for that frame. The FSM follows the new edge direction; the counter restarts at 0.
- Long slot: k saturates and data is ignored until the next edge. This is not an error unless the feature is enabled.
- Direction mismatch: lrclk is 1-bit, so edges always alternate and no illegal transition exists.
- Reset mid-frame: all state returns to reset values in the same cycle. The next pair is delivered only after a fresh falling edge.

Optional Feature:
- Macro: I2S_RX_FRAME_ERR_EN.
- With the macro: at each edge cycle outside SYNC, compare the finished slot's length (k value at the edge, counting 1-based) against SLOT_BITS. On a mismatch, pulse o_frame_err for 1 cycle.
- Also with the macro: a short slot additionally forces the FSM to SYNC, so the receiver resyncs on the next falling edge.
- Without the macro: o_frame_err is tied 0, length checking logic is absent, and short slots behave as described under Behaviour.

Decomposition:
- Package i2s_pkg: the state enum (SYNC/LEFT/RIGHT), the default DATA_RES/SLOT_BITS localparams, and a lrclk channel-encoding constant (LEFT_CH=0). The transmitter shares this package.
- One sub-module, i2s_rx_chan: bit counter plus MSB-first shift register with k-window capture. The top instantiates one counter/shifter pair and steers the latch by FSM state.

Test Plan:
- Reset, then a falling lrclk followed by a standard frame L=24'hA5_5A_01, R=24'h80_0001 -> o_valid pulses once, 1 sclk after the right LSB; o_ldout=24'hA55A01, o_rdout=24'h800001.
- Stream starts mid right slot (lrclk=1 at reset release) -> no o_valid until after the first full L/R following a falling edge.
- Back-to-back frames 24'hFFFFFF/24'h000000, then 24'h000000/24'hFFFFFF -> two pulses exactly 64 sclk apart; outputs hold between pulses.
- Left slot shortened to 16 sclk -> no o_valid for that frame; the next normal frame is received correctly. With I2S_RX_FRAME_ERR_EN: o_frame_err pulses at the short slot's closing edge.
- Assert reset for 1 cycle at k=10 of the right slot -> outputs go to 0, o_valid stays 0, recovery on the next falling edge.
- SLOT_BITS=32 with a 34-sclk slot -> data is still correct. Without the macro o_frame_err=0; with it, one pulse.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared I2S definitions: receiver FSM states, default slot geometry and
// lrclk channel encoding. Also used by the I2S transmitter.
package i2s_pkg;

  // Default geometry: 32-bit slots carrying 24 MSB-aligned data bits.
  localparam int unsigned DATA_RES_DEF  = 24;
  localparam int unsigned SLOT_BITS_DEF = 32;

  // lrclk level that selects the left channel.
  localparam logic LEFT_CH = 1'b0;

  typedef enum logic [1:0] {
    StSync,
    StLeft,
    StRight
  } i2s_state_e;

  // Slot index counter width; k runs 0..SLOT_BITS+1.
  function automatic int unsigned cnt_width(input int unsigned slot_bits);
    return $clog2(slot_bits + 2);
  endfunction

endpackage

// File: rtl/i2s_rx_chan.sv
// I2S receive bit-slot tracker: slot index counter k (0 on each lrclk edge,
// saturating at SLOT_BITS+1) and an MSB-first shift register that only
// captures sdin while 1 <= k <= DATA_RES.
module i2s_rx_chan
  import i2s_pkg::*;
#(
  parameter int unsigned DATA_RES  = DATA_RES_DEF,
  parameter int unsigned SLOT_BITS = SLOT_BITS_DEF,
  parameter int unsigned CNT_W     = cnt_width(SLOT_BITS)
) (
  input  logic                sclk,
  input  logic                reset,
  input  logic                lr_edge,
  input  logic                sdin,
  output logic [CNT_W-1:0]    k_prev,
  output logic                last_bit,
  output logic [DATA_RES-1:0] word_d,
  output logic [DATA_RES-1:0] word_q
);

  localparam logic [CNT_W-1:0] KSat  = CNT_W'(SLOT_BITS + 1);
  localparam logic [CNT_W-1:0] KLast = CNT_W'(DATA_RES);

  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    k;
  logic                capture;
  logic [DATA_RES-1:0] shreg_q;

  // Slot index for the current cycle and the capture window.
  always_comb begin
    k = cnt_q;
    if (lr_edge) begin
      k = '0;
    end else if (cnt_q != KSat) begin
      k = cnt_q + CNT_W'(1);
    end
    capture  = (k != '0) && (k <= KLast);
    last_bit = (k == KLast);
    word_d   = capture ? {shreg_q[DATA_RES-2:0], sdin} : shreg_q;
  end

  // Counter and shift register state.
  always_ff @(posedge sclk) begin
    if (reset) begin
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      cnt_q   <= k;
      shreg_q <= word_d;
    end
  end

  // k of the previous cycle; at an edge, this plus one is the closed slot length.
  assign k_prev = cnt_q;
  assign word_q = shreg_q;

endmodule

// File: rtl/i2s_rx.sv
// I2S (Philips) stereo receiver: deserialises left/right words from sdin,
// presents them together with a one-cycle o_valid pulse.
// Optional slot-length checking and resync: define I2S_RX_FRAME_ERR_EN.
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int unsigned DATA_RES  = DATA_RES_DEF,
  parameter int unsigned SLOT_BITS = SLOT_BITS_DEF
) (
  input  logic                sclk,
  input  logic                reset,
  input  logic                lrclk,
  input  logic                i_sdin,
  output logic [DATA_RES-1:0] o_ldout,
  output logic [DATA_RES-1:0] o_rdout,
  output logic                o_valid,
  output logic                o_frame_err
);

  localparam int unsigned CNT_W = cnt_width(SLOT_BITS);

  if (DATA_RES < 2 || DATA_RES + 1 > SLOT_BITS) begin : g_bad_cfg
    $error("i2s_rx: need 2 <= DATA_RES and DATA_RES+1 <= SLOT_BITS");
  end

  logic                lrclk_q;
  logic                lr_edge;
  logic                lr_fall;
  i2s_state_e          state_q, state_d;
  logic [CNT_W-1:0]    k_prev;
  logic                last_bit;
  logic [DATA_RES-1:0] word_d;
  logic [DATA_RES-1:0] word_q;
  logic [DATA_RES-1:0] lhold_q;
  logic                lvalid_q;
  logic                pend_q;
  logic [DATA_RES-1:0] ldout_q;
  logic [DATA_RES-1:0] rdout_q;
  logic                valid_q;

  assign lr_edge = (lrclk != lrclk_q);
  assign lr_fall = lr_edge && (lrclk == LEFT_CH);

  i2s_rx_chan #(
    .DATA_RES  (DATA_RES),
    .SLOT_BITS (SLOT_BITS),
    .CNT_W     (CNT_W)
  ) u_chan (
    .sclk     (sclk),
    .reset    (reset),
    .lr_edge  (lr_edge),
    .sdin     (i_sdin),
    .k_prev   (k_prev),
    .last_bit (last_bit),
    .word_d   (word_d),
    .word_q   (word_q)
  );

`ifdef I2S_RX_FRAME_ERR_EN
  logic short_slot;
  logic len_err;
  logic frame_err_q;

  // Slot-length checks at an edge closing a tracked slot.
  always_comb begin
    short_slot = lr_edge && (state_q != StSync) && (k_prev < CNT_W'(DATA_RES));
    len_err    = lr_edge && (state_q != StSync) && (k_prev != CNT_W'(SLOT_BITS - 1));
  end

  // One-cycle frame error pulse.
  always_ff @(posedge sclk) begin
    if (reset) begin
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= len_err;
    end
  end

  assign o_frame_err = frame_err_q;
`else
  // Slot length is not tracked in this build.
  logic unused_k_prev;
  assign unused_k_prev = ^k_prev;
  assign o_frame_err   = 1'b0;
`endif

  // Next-state: only a falling edge leaves SYNC so pairs always start with left.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StSync:  if (lr_fall) state_d = StLeft;
      StLeft:  if (lr_edge && !lr_fall) state_d = StRight;
      StRight: if (lr_fall) state_d = StLeft;
      default: state_d = StSync;
    endcase
`ifdef I2S_RX_FRAME_ERR_EN
    if (short_slot) state_d = StSync;
`endif
  end

  // State register and lrclk edge history.
  always_ff @(posedge sclk) begin
    if (reset) begin
      state_q <= StSync;
      lrclk_q <= 1'b1;
    end else begin
      state_q <= state_d;
      lrclk_q <= lrclk;
    end
  end

  // Left hold: latched at the left LSB, invalidated at every new left slot.
  always_ff @(posedge sclk) begin
    if (reset) begin
      lhold_q  <= '0;
      lvalid_q <= 1'b0;
    end else if (lr_fall) begin
      lvalid_q <= 1'b0;
    end else if (state_q == StLeft && last_bit) begin
      lhold_q  <= word_d;
      lvalid_q <= 1'b1;
    end
  end

  // Present the pair one cycle after the right LSB lands in the shifter.
  always_ff @(posedge sclk) begin
    if (reset) begin
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
      ldout_q <= '0;
      rdout_q <= '0;
    end else begin
      pend_q  <= (state_q == StRight) && last_bit && lvalid_q;
      valid_q <= pend_q;
      if (pend_q) begin
        ldout_q <= lhold_q;
        rdout_q <= word_q;
      end
    end
  end

  assign o_ldout = ldout_q;
  assign o_rdout = rdout_q;
  assign o_valid = valid_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: frame table plus reset/mid-slot start sequences.
module tb_i2s_rx;

  localparam int DR = 24;

`ifdef I2S_RX_FRAME_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic          sclk = 1'b0;
  logic          reset;
  logic          lrclk;
  logic          i_sdin;
  logic [DR-1:0] o_ldout;
  logic [DR-1:0] o_rdout;
  logic          o_valid;
  logic          o_frame_err;

  always #5 sclk = ~sclk;

  i2s_rx #(
    .DATA_RES  (24),
    .SLOT_BITS (32)
  ) dut (
    .sclk        (sclk),
    .reset       (reset),
    .lrclk       (lrclk),
    .i_sdin      (i_sdin),
    .o_ldout     (o_ldout),
    .o_rdout     (o_rdout),
    .o_valid     (o_valid),
    .o_frame_err (o_frame_err)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int lsb_cyc;

  // Monitor state, sampled on the falling edge.
  int            vcnt   = 0;
  int            ecnt   = 0;
  int            glitch = 0;
  int            vcyc   = 0;
  logic [DR-1:0] pl     = '0;
  logic [DR-1:0] pr     = '0;

  always @(posedge sclk) cyc <= cyc + 1;

  always @(negedge sclk) begin
    if (o_valid === 1'b1) begin
      vcnt <= vcnt + 1;
      vcyc <= cyc;
    end
    if (o_frame_err === 1'b1) ecnt <= ecnt + 1;
    if (o_valid !== 1'b1 && (o_ldout !== pl || o_rdout !== pr)) glitch <= glitch + 1;
    pl <= o_ldout;
    pr <= o_rdout;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One slot: k=0 edge cycle, data at k=1..DR, junk ones elsewhere.
  task automatic send_slot(input logic lr, input logic [DR-1:0] w, input int len,
                           input int rst_at);
    for (int i = 0; i < len; i++) begin
      logic b;
      b = (i >= 1 && i <= DR) ? w[DR-i] : 1'b1;
      @(negedge sclk);
      lrclk  = lr;
      i_sdin = b;
      reset  = (i == rst_at);
      if (i == DR) lsb_cyc = cyc + 1;
    end
  endtask

  typedef struct {
    logic [DR-1:0] l;
    logic [DR-1:0] r;
    int            llen;
    int            nvalid;
    logic [DR-1:0] el;
    logic [DR-1:0] er;
    int            nerr;
  } vec_t;

  vec_t tbl[7];
  int   vt[7];

  initial begin
    int v0, e0;
    tbl[0] = '{24'hA55A01, 24'h800001, 32, 1, 24'hA55A01, 24'h800001, 0};
    tbl[1] = '{24'hFFFFFF, 24'h000000, 32, 1, 24'hFFFFFF, 24'h000000, 0};
    tbl[2] = '{24'h000000, 24'hFFFFFF, 32, 1, 24'h000000, 24'hFFFFFF, 0};
    tbl[3] = '{24'h123456, 24'hABCDEF, 16, 0, 24'h000000, 24'hFFFFFF, 1};
    tbl[4] = '{24'h654321, 24'hFEDCBA, 32, 1, 24'h654321, 24'hFEDCBA, 0};
    tbl[5] = '{24'h0F0F0F, 24'hF0F0F0, 34, 1, 24'h0F0F0F, 24'hF0F0F0, 1};
    tbl[6] = '{24'hC00003, 24'h7FFFFE, 32, 1, 24'hC00003, 24'h7FFFFE, 0};

    reset  = 1'b1;
    lrclk  = 1'b1;
    i_sdin = 1'b0;
    repeat (3) @(negedge sclk);
    #1;
    check("reset_ldout", o_ldout, 0);
    check("reset_rdout", o_rdout, 0);
    check("reset_valid", o_valid, 0);
    check("reset_frame_err", o_frame_err, 0);

    // Release in the middle of a right slot; nothing may be delivered.
    @(negedge sclk);
    reset = 1'b0;
    repeat (10) begin
      @(negedge sclk);
      lrclk  = 1'b1;
      i_sdin = 1'($urandom_range(0, 1));
    end
    #1;
    check("midslot_no_valid", vcnt, 0);

    for (int n = 0; n < 7; n++) begin
      v0 = vcnt;
      e0 = ecnt;
      send_slot(1'b0, tbl[n].l, tbl[n].llen, -1);
      send_slot(1'b1, tbl[n].r, 32, -1);
      #1;
      vt[n] = vcyc;
      check($sformatf("vec%0d_valid_count", n), vcnt - v0, tbl[n].nvalid);
      check($sformatf("vec%0d_ldout", n), o_ldout, tbl[n].el);
      check($sformatf("vec%0d_rdout", n), o_rdout, tbl[n].er);
      check($sformatf("vec%0d_frame_err", n), ecnt - e0, ErrEn ? tbl[n].nerr : 0);
      if (tbl[n].nvalid == 1) begin
        check($sformatf("vec%0d_latency", n), vcyc - lsb_cyc, 1);
      end
    end
    check("b2b_spacing", vt[2] - vt[1], 64);
    check("outputs_hold", glitch, 0);

    // Reset pulse at k=10 of a right slot.
    v0 = vcnt;
    send_slot(1'b0, 24'h3C3C3C, 32, -1);
    send_slot(1'b1, 24'hC3C3C3, 32, 10);
    #1;
    check("rst_mid_ldout", o_ldout, 0);
    check("rst_mid_rdout", o_rdout, 0);
    check("rst_mid_no_valid", vcnt - v0, 0);
    check("rst_mid_valid_low", o_valid, 0);

    // Recovery on the next falling edge.
    v0 = vcnt;
    send_slot(1'b0, 24'h5A5A5A, 32, -1);
    send_slot(1'b1, 24'h0000FF, 32, -1);
    #1;
    check("recover_valid_count", vcnt - v0, 1);
    check("recover_ldout", o_ldout, 24'h5A5A5A);
    check("recover_rdout", o_rdout, 24'h0000FF);

    repeat (4) @(negedge sclk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
